// File: rtl/ctrl_mc.sv
// ctrl_mc: multicycle control sequencer for the SISC datapath.
// The sequencer moves through START, FETCH, DECODE, EXECUTE, MEM, MEM_WAIT and WRITEBACK.
// It decodes the opcode to drive the PC, IR, RF, ALU and DMEM controls.
// Conditional branches are resolved in DECODE against stat & mm.
// LOD/STR wait on a DMEM handshake. A handshake that never arrives is cut off after
// MEM_TMO wait cycles: the sequencer sets the sticky mem_err flag and parks in HALT.
// The control outputs are a pure decode of the state register plus the IR and status fields.
// This lets DECODE react to the IR loaded at the end of FETCH, and lets an asynchronous
// reset drop any memory request at once.
module ctrl_mc #(
    parameter int OP_W     = 4,
    parameter int ALU_OP_W = 4,
    parameter int MEM_TMO  = 15,
    parameter int WCNT_W   = 4
) (
    input  logic                clk,
    input  logic                rst_f,
    input  logic [OP_W-1:0]     opcode,
    input  logic [3:0]          mm,
    input  logic [3:0]          stat,
    input  logic                mem_ack,
    output logic                rf_we,
    output logic                wb_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                br_sel,
    output logic                pc_rst,
    output logic                pc_write,
    output logic                pc_sel,
    output logic                ir_load,
    output logic                dm_re,
    output logic                dm_we,
    output logic                halted,
    output logic                mem_err
);

    // Opcode map (zero-extended to OP_W); unlisted encodings behave as NOOP.
    localparam logic [OP_W-1:0] OP_NOOP   = OP_W'(4'd0);
    localparam logic [OP_W-1:0] OP_REG_OP = OP_W'(4'd1);
    localparam logic [OP_W-1:0] OP_REG_IM = OP_W'(4'd2);
    localparam logic [OP_W-1:0] OP_BRA    = OP_W'(4'd4);
    localparam logic [OP_W-1:0] OP_BRR    = OP_W'(4'd5);
    localparam logic [OP_W-1:0] OP_BNE    = OP_W'(4'd6);
    localparam logic [OP_W-1:0] OP_BNR    = OP_W'(4'd7);
    localparam logic [OP_W-1:0] OP_LOD    = OP_W'(4'd10);
    localparam logic [OP_W-1:0] OP_STR    = OP_W'(4'd11);
    localparam logic [OP_W-1:0] OP_HLT    = OP_W'(4'd15);

    // ALU operation codes used by the sequencer.
    localparam logic [ALU_OP_W-1:0] ALU_ZERO = ALU_OP_W'(3'd0);
    localparam logic [ALU_OP_W-1:0] ALU_ONE  = ALU_OP_W'(3'd1);
    localparam logic [ALU_OP_W-1:0] ALU_TWO  = ALU_OP_W'(3'd2);
    localparam logic [ALU_OP_W-1:0] ALU_IMM  = ALU_OP_W'(3'd3);
    localparam logic [ALU_OP_W-1:0] ALU_ADDR = ALU_OP_W'(3'd4);

    // Wait-counter constants.
    localparam logic [WCNT_W-1:0] WCNT_ZERO = {WCNT_W{1'b0}};
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1'b1);
    localparam logic [WCNT_W-1:0] WCNT_TMO  = WCNT_W'(MEM_TMO);

    typedef enum logic [2:0] {
        S_START     = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_MEM_WAIT  = 3'd5,
        S_WRITEBACK = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    state_t              state_r;
    logic [WCNT_W-1:0]   wait_cnt_r;
    logic                mem_err_r;

    logic                is_lod_s;
    logic                is_str_s;
    logic                is_mem_s;
    logic                is_rf_wr_s;
    logic                is_abs_br_s;
    logic                taken_s;

    // Branch resolution: BRA/BRR take on any selected CC set, BNE/BNR on none set.
    function automatic logic br_taken(input logic [OP_W-1:0] op,
                                      input logic [3:0]      cc,
                                      input logic [3:0]      mask);
        logic hit;
        hit = ((cc & mask) != 4'd0);
        case (op)
            OP_BRA, OP_BRR: br_taken = hit;
            OP_BNE, OP_BNR: br_taken = !hit;
            default:        br_taken = 1'b0;
        endcase
    endfunction

    // ALU operation during EXECUTE.
    function automatic logic [ALU_OP_W-1:0] alu_exec(input logic [OP_W-1:0] op);
        case (op)
            OP_REG_OP:      alu_exec = ALU_ONE;
            OP_REG_IM:      alu_exec = ALU_IMM;
            OP_LOD, OP_STR: alu_exec = ALU_ADDR;
            default:        alu_exec = ALU_ZERO;
        endcase
    endfunction

    // ALU operation during MEM and MEM_WAIT (holds the address for memory ops).
    function automatic logic [ALU_OP_W-1:0] alu_mem(input logic [OP_W-1:0] op);
        case (op)
            OP_REG_OP:      alu_mem = ALU_ZERO;
            OP_REG_IM:      alu_mem = ALU_TWO;
            OP_LOD, OP_STR: alu_mem = ALU_ADDR;
            default:        alu_mem = ALU_ZERO;
        endcase
    endfunction

    // Opcode classification shared by the FSM and the output decode.
    always_comb begin
        is_lod_s    = (opcode == OP_LOD);
        is_str_s    = (opcode == OP_STR);
        is_mem_s    = is_lod_s || is_str_s;
        is_rf_wr_s  = (opcode == OP_REG_OP) || (opcode == OP_REG_IM) || is_lod_s;
        is_abs_br_s = (opcode == OP_BRA) || (opcode == OP_BNE);
        taken_s     = br_taken(opcode, stat, mm);
    end

    // Sequencer state, DMEM wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_r    <= S_START;
            wait_cnt_r <= WCNT_ZERO;
            mem_err_r  <= 1'b0;
        end else begin
            case (state_r)
                S_START: begin
                    state_r <= S_FETCH;
                end
                S_FETCH: begin
                    state_r <= S_DECODE;
                end
                S_DECODE: begin
                    if (opcode == OP_HLT) begin
                        state_r <= S_HALT;
                    end else begin
                        state_r <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    state_r <= S_MEM;
                end
                S_MEM: begin
                    if (is_mem_s && !mem_ack) begin
                        state_r    <= S_MEM_WAIT;
                        wait_cnt_r <= WCNT_ONE;
                    end else begin
                        state_r <= S_WRITEBACK;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_ack) begin
                        state_r    <= S_WRITEBACK;
                        wait_cnt_r <= WCNT_ZERO;
                    end else if (wait_cnt_r == WCNT_TMO) begin
                        state_r   <= S_HALT;
                        mem_err_r <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WCNT_ONE;
                    end
                end
                S_WRITEBACK: begin
                    state_r <= S_FETCH;
                end
                S_HALT: begin
                    state_r <= S_HALT;
                end
                default: begin
                    state_r <= S_START;
                end
            endcase
        end
    end

    // Moore output decode: everything low unless the current state asserts it.
    always_comb begin
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        alu_op   = ALU_ZERO;
        br_sel   = 1'b0;
        pc_rst   = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        ir_load  = 1'b0;
        dm_re    = 1'b0;
        dm_we    = 1'b0;
        halted   = 1'b0;
        case (state_r)
            S_START: begin
                pc_rst = 1'b1;
            end
            S_FETCH: begin
                ir_load  = 1'b1;
                pc_write = 1'b1;
                pc_sel   = 1'b0;
            end
            S_DECODE: begin
                if (taken_s) begin
                    pc_sel   = 1'b1;
                    pc_write = 1'b1;
                    br_sel   = is_abs_br_s;
                end else begin
                    pc_sel   = 1'b0;
                    pc_write = 1'b0;
                    br_sel   = 1'b0;
                end
            end
            S_EXECUTE: begin
                alu_op = alu_exec(opcode);
            end
            S_MEM, S_MEM_WAIT: begin
                alu_op = alu_mem(opcode);
                dm_re  = is_lod_s;
                dm_we  = is_str_s;
            end
            S_WRITEBACK: begin
                rf_we  = is_rf_wr_s;
                wb_sel = is_lod_s;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                pc_rst = 1'b0;
            end
        endcase
    end

    // The timeout flag is observed directly from its register.
    assign mem_err = mem_err_r;

endmodule

// File: tb/tb_ctrl_mc.sv
// tb_ctrl_mc: directed bench for ctrl_mc. Each instruction's expected per-cycle output
// vector is pushed to a scoreboard queue along with the mem_ack value for that cycle,
// then popped and compared one clock at a time.
module tb_ctrl_mc;

    logic       clk;
    logic       rst_f;
    logic [3:0] opcode;
    logic [3:0] mm;
    logic [3:0] stat;
    logic       mem_ack;
    logic       rf_we, wb_sel, br_sel, pc_rst, pc_write, pc_sel;
    logic       ir_load, dm_re, dm_we, halted, mem_err;
    logic [3:0] alu_op;
    logic [14:0] obs;

    int checks   = 0;
    int failures = 0;

    // Packed output vector: {rf_we, wb_sel, alu_op, br_sel, pc_rst, pc_write, pc_sel,
    //                        ir_load, dm_re, dm_we, halted, mem_err}
    localparam logic [14:0] V_0   = 15'h0000;
    localparam logic [14:0] V_RF  = 15'h4000;
    localparam logic [14:0] V_WB  = 15'h2000;
    localparam logic [14:0] V_BR  = 15'h0100;
    localparam logic [14:0] V_PCR = 15'h0080;
    localparam logic [14:0] V_PCW = 15'h0040;
    localparam logic [14:0] V_PCS = 15'h0020;
    localparam logic [14:0] V_IRL = 15'h0010;
    localparam logic [14:0] V_RE  = 15'h0008;
    localparam logic [14:0] V_WE  = 15'h0004;
    localparam logic [14:0] V_HLT = 15'h0002;
    localparam logic [14:0] V_ERR = 15'h0001;
    localparam logic [14:0] V_F   = 15'h0050;   // FETCH: ir_load | pc_write

    typedef struct {
        string       tag;
        logic        ack;
        logic [14:0] exp;
    } sb_t;

    sb_t sb_q[$];

    assign obs = {rf_we, wb_sel, alu_op, br_sel, pc_rst, pc_write, pc_sel,
                  ir_load, dm_re, dm_we, halted, mem_err};

    ctrl_mc #(
        .OP_W     (4),
        .ALU_OP_W (4),
        .MEM_TMO  (15),
        .WCNT_W   (4)
    ) dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .opcode   (opcode),
        .mm       (mm),
        .stat     (stat),
        .mem_ack  (mem_ack),
        .rf_we    (rf_we),
        .wb_sel   (wb_sel),
        .alu_op   (alu_op),
        .br_sel   (br_sel),
        .pc_rst   (pc_rst),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .ir_load  (ir_load),
        .dm_re    (dm_re),
        .dm_we    (dm_we),
        .halted   (halted),
        .mem_err  (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] alu(input logic [3:0] n);
        logic [14:0] v;
        v = 15'h0000;
        v[12:9] = n;
        return v;
    endfunction

    task automatic check(input string tag, input logic [14:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic ack, input logic [14:0] exp);
        sb_t e;
        e.tag = tag;
        e.ack = ack;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Pop every queued expectation, one clock per entry.
    task automatic drain();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            mem_ack = e.ack;
            #1;
            check(e.tag, e.exp);
            @(posedge clk);
            #1;
        end
        mem_ack = 1'b0;
    endtask

    task automatic set_ir(input logic [3:0] op, input logic [3:0] st, input logic [3:0] m);
        opcode = op;
        stat   = st;
        mm     = m;
    endtask

    // Asynchronous reset pulse, leaving the DUT in FETCH.
    task automatic reset_now(input string tag);
        rst_f = 1'b0;
        #1;
        check({tag, "_async"}, V_PCR);
        @(posedge clk);
        #1;
        rst_f = 1'b1;
        check({tag, "_start"}, V_PCR);
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_f   = 1'b0;
        mem_ack = 1'b0;
        set_ir(4'd0, 4'd0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_start", V_PCR);
        rst_f = 1'b1;
        #1;
        check("start_released", V_PCR);
        @(posedge clk);
        #1;

        // REG_OP
        set_ir(4'd1, 4'd0, 4'd0);
        push("regop_fetch", 1'b0, V_F);
        push("regop_decode", 1'b0, V_0);
        push("regop_exec", 1'b0, alu(4'd1));
        push("regop_mem", 1'b0, alu(4'd0));
        push("regop_wb", 1'b0, V_RF);
        drain();

        // REG_IM
        set_ir(4'd2, 4'd0, 4'd0);
        push("regim_fetch", 1'b0, V_F);
        push("regim_decode", 1'b0, V_0);
        push("regim_exec", 1'b0, alu(4'd3));
        push("regim_mem", 1'b0, alu(4'd2));
        push("regim_wb", 1'b0, V_RF);
        drain();

        // BRR taken, relative
        set_ir(4'd5, 4'b0100, 4'b0100);
        push("brr_fetch", 1'b0, V_F);
        push("brr_decode", 1'b0, V_PCW | V_PCS);
        push("brr_exec", 1'b0, V_0);
        push("brr_mem", 1'b0, V_0);
        push("brr_wb", 1'b0, V_0);
        drain();

        // BNE with the same CCs: not taken
        set_ir(4'd6, 4'b0100, 4'b0100);
        push("bne_fetch", 1'b0, V_F);
        push("bne_decode", 1'b0, V_0);
        push("bne_exec", 1'b0, V_0);
        push("bne_mem", 1'b0, V_0);
        push("bne_wb", 1'b0, V_0);
        drain();

        // BRA taken, absolute
        set_ir(4'd4, 4'b0001, 4'b0011);
        push("bra_fetch", 1'b0, V_F);
        push("bra_decode", 1'b0, V_PCW | V_PCS | V_BR);
        push("bra_exec", 1'b0, V_0);
        push("bra_mem", 1'b0, V_0);
        push("bra_wb", 1'b0, V_0);
        drain();

        // BNR taken (no selected CC set), relative
        set_ir(4'd7, 4'b1000, 4'b0111);
        push("bnr_fetch", 1'b0, V_F);
        push("bnr_decode", 1'b0, V_PCW | V_PCS);
        push("bnr_exec", 1'b0, V_0);
        push("bnr_mem", 1'b0, V_0);
        push("bnr_wb", 1'b0, V_0);
        drain();

        // BRA not taken
        set_ir(4'd4, 4'b0001, 4'b0010);
        push("bra_nt_fetch", 1'b0, V_F);
        push("bra_nt_decode", 1'b0, V_0);
        push("bra_nt_exec", 1'b0, V_0);
        drain();
        push("bra_nt_mem", 1'b0, V_0);
        push("bra_nt_wb", 1'b0, V_0);
        drain();

        // Undefined opcode acts as NOOP; stray mem_ack ignored
        set_ir(4'd3, 4'b1111, 4'b1111);
        push("noop_fetch", 1'b1, V_F);
        push("noop_decode", 1'b1, V_0);
        push("noop_exec", 1'b1, V_0);
        push("noop_mem", 1'b0, V_0);
        push("noop_wb", 1'b1, V_0);
        drain();

        // LOD with mem_ack after 3 wait cycles
        set_ir(4'd10, 4'd0, 4'd0);
        push("lod_fetch", 1'b0, V_F);
        push("lod_decode", 1'b0, V_0);
        push("lod_exec", 1'b0, alu(4'd4));
        push("lod_mem", 1'b0, alu(4'd4) | V_RE);
        push("lod_wait1", 1'b0, alu(4'd4) | V_RE);
        push("lod_wait2", 1'b0, alu(4'd4) | V_RE);
        push("lod_wait3", 1'b1, alu(4'd4) | V_RE);
        push("lod_wb", 1'b0, V_RF | V_WB);
        push("lod_next_fetch", 1'b0, V_F);
        drain();

        // STR acked in MEM: no wait, no RF write (already in DECODE now)
        set_ir(4'd11, 4'd0, 4'd0);
        push("str_decode", 1'b0, V_0);
        push("str_exec", 1'b0, alu(4'd4));
        push("str_mem", 1'b1, alu(4'd4) | V_WE);
        push("str_wb", 1'b0, V_0);
        drain();

        // HLT
        set_ir(4'd15, 4'd0, 4'd0);
        push("hlt_fetch", 1'b0, V_F);
        push("hlt_decode", 1'b0, V_0);
        push("hlt_halt1", 1'b1, V_HLT);
        push("hlt_halt2", 1'b0, V_HLT);
        push("hlt_halt3", 1'b0, V_HLT);
        drain();
        reset_now("hlt_reset");

        // STR with no mem_ack: timeout after 15 wait cycles
        set_ir(4'd11, 4'd0, 4'd0);
        push("tmo_fetch", 1'b0, V_F);
        push("tmo_decode", 1'b0, V_0);
        push("tmo_exec", 1'b0, alu(4'd4));
        push("tmo_mem", 1'b0, alu(4'd4) | V_WE);
        for (int i = 1; i <= 15; i++) begin
            push($sformatf("tmo_wait%0d", i), 1'b0, alu(4'd4) | V_WE);
        end
        push("tmo_halt1", 1'b0, V_HLT | V_ERR);
        push("tmo_halt2", 1'b1, V_HLT | V_ERR);
        push("tmo_halt3", 1'b0, V_HLT | V_ERR);
        drain();
        reset_now("tmo_reset");

        // LOD interrupted by reset while in MEM_WAIT
        set_ir(4'd10, 4'd0, 4'd0);
        push("rstw_fetch", 1'b0, V_F);
        push("rstw_decode", 1'b0, V_0);
        push("rstw_exec", 1'b0, alu(4'd4));
        push("rstw_mem", 1'b0, alu(4'd4) | V_RE);
        push("rstw_wait1", 1'b0, alu(4'd4) | V_RE);
        drain();
        reset_now("rstw_reset");

        // Normal operation resumes after the interrupted access
        set_ir(4'd1, 4'd0, 4'd0);
        push("resume_fetch", 1'b0, V_F);
        push("resume_decode", 1'b0, V_0);
        push("resume_exec", 1'b0, alu(4'd1));
        push("resume_mem", 1'b0, alu(4'd0));
        push("resume_wb", 1'b0, V_RF);
        push("resume_next_fetch", 1'b0, V_F);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
